// File: rtl/blink_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blink_seq_pkg
// Purpose  : Shared types, constants and helpers for the blink sequencer:
//            FSM state encoding, prescaler/gap counter width helpers and the
//            round-robin pick function used by the requester arbiter.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package blink_seq_pkg;

  // FSM state encoding. The enum documents the encoding; the localparams are
  // the constants the sequencer register actually uses.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // Largest supported requester count; the arbiter works on this width.
  localparam int MAX_REQ = 8;

  // Prescaler width: $clog2(HALF_PERIOD), never narrower than one bit.
  function automatic int presc_width(input int half_period);
    return (half_period > 1) ? $clog2(half_period) : 1;
  endfunction

  // Gap half-period counter width, never narrower than one bit.
  function automatic int gap_width(input int gap_halves);
    return (gap_halves > 1) ? $clog2(gap_halves) : 1;
  endfunction

  // Widths for the default configuration (HALF_PERIOD=50e6, GAP_HALVES=2).
  localparam int PRESC_W_DEFAULT = presc_width(50000000);
  localparam int GAP_W_DEFAULT   = gap_width(2);

  // Round-robin pick: first set bit of req searching upward from ptr,
  // wrapping at nreq. Caller qualifies the result with |req.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 nreq);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (!found && (k < nreq) && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/blink_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : blink_prescaler
// Purpose  : Half-period prescaler. Counts 0..HALF_PERIOD-1 while enabled and
//            flags the terminal count.
// Ports    : clk   - system clock
//            rst_n - synchronous active-low reset
//            clr   - synchronous clear (wins over en)
//            en    - count enable
//            tc    - terminal count (count == HALF_PERIOD-1 while enabled)
// Revision : 1.0 - initial release
// ============================================================================
module blink_prescaler
  import blink_seq_pkg::*;
#(
  parameter int HALF_PERIOD = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int             CW     = presc_width(HALF_PERIOD);
  localparam logic [CW-1:0]  TC_VAL = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == TC_VAL) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tc = en && (r_cnt == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : blink_sequencer
// Purpose  : Shared-LED blink-code controller. A round-robin arbiter grants
//            the LED to one requester, which then shows N pulses (one
//            half-period ON, one half-period OFF each) followed by a gap.
// Ports    : clk       - system clock, all logic on posedge
//            rst_n     - synchronous active-low reset
//            req       - [NREQ] level request per requester
//            blink_cnt - [NREQ*CNT_W] pulse count, field i = [i*CNT_W +: CNT_W]
//            gnt       - [NREQ] one-hot grant, zero when idle
//            done      - [NREQ] one-cycle completion pulse
//            busy      - high while not idle
//            led       - registered LED drive
// Options  : BLINK_HEARTBEAT_EN - idle heartbeat (led toggles every
//            2*HALF_PERIOD cycles while idle)
// Revision : 1.0 - initial release
// ============================================================================
module blink_sequencer
  import blink_seq_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HALF_PERIOD = 50000000,
  parameter int GAP_HALVES  = 2,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] blink_cnt,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  led
);

  localparam int               GAP_W    = gap_width(GAP_HALVES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_HALVES - 1);
  localparam logic [2:0]       PTR_LAST = 3'(NREQ - 1);

  logic [1:0]         r_state;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    r_done;
  logic [2:0]         r_idx;
  logic [2:0]         r_ptr;
  logic [CNT_W-1:0]   r_rem;
  logic [GAP_W-1:0]   r_gap;
  logic               r_led;

  logic [MAX_REQ-1:0] w_req_ext;
  logic [2:0]         w_pick;
  logic [NREQ-1:0]    w_onehot;
  logic [CNT_W-1:0]   w_pick_cnt;
  logic               w_any;
  logic               w_held;
  logic               w_tc;
  logic               w_idle;
  logic               w_start;
  logic               w_gap_end;
  logic               w_to_idle;
  logic               w_clr;
  logic               w_en;
  logic [2:0]         w_next_ptr;

  // ---------------------------------------------------------------- arbiter
  always_comb begin
    w_req_ext           = '0;
    w_req_ext[NREQ-1:0] = req;
  end

  assign w_pick     = rr_pick(w_req_ext, r_ptr, NREQ);
  assign w_any      = |req;
  assign w_pick_cnt = blink_cnt[int'(w_pick)*CNT_W +: CNT_W];

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_onehot[i] = (w_pick == 3'(i));
    end
  end

  // Granted requester still asserting; r_gnt is one-hot so a mask suffices.
  assign w_held     = |(req & r_gnt);
  assign w_next_ptr = (r_idx == PTR_LAST) ? 3'd0 : r_idx + 3'd1;

  // ------------------------------------------------------------- prescaler
  assign w_idle    = (r_state == S_IDLE);
  assign w_start   = w_idle && w_any;
  assign w_gap_end = (r_state == S_GAP) && w_tc && (r_gap == GAP_LAST);
  assign w_to_idle = !w_idle && (!w_held || w_gap_end);

`ifdef BLINK_HEARTBEAT_EN
  // Free-running in idle; restarted on grant and on return to idle so the
  // heartbeat phase always begins at zero.
  assign w_en  = 1'b1;
  assign w_clr = w_start || w_to_idle;
`else
  assign w_en  = !w_idle;
  assign w_clr = w_idle || w_to_idle;
`endif

  blink_prescaler #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .en    (w_en),
    .tc    (w_tc)
  );

`ifdef BLINK_HEARTBEAT_EN
  // Idle half-period parity: led toggles on every second terminal count.
  logic r_hb_half;

  always_ff @(posedge clk) begin
    if (!rst_n || w_clr) begin
      r_hb_half <= 1'b0;
    end else if (w_idle && w_tc) begin
      r_hb_half <= ~r_hb_half;
    end
  end
`endif

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_gap   <= '0;
      r_led   <= 1'b0;
    end else begin
      r_done <= '0;
      if (w_idle) begin
        if (w_any) begin
          r_gnt <= w_onehot;
          r_idx <= w_pick;
          r_rem <= w_pick_cnt;
          r_gap <= '0;
          // A zero-pulse code goes straight to the gap with the LED dark.
          if (w_pick_cnt == '0) begin
            r_state <= S_GAP;
            r_led   <= 1'b0;
          end else begin
            r_state <= S_ON;
            r_led   <= 1'b1;
          end
        end
`ifdef BLINK_HEARTBEAT_EN
        else if (w_tc && r_hb_half) begin
          r_led <= ~r_led;
        end
`endif
      end else if (!w_held) begin
        // Abort: requester withdrew; release without a done pulse.
        r_state <= S_IDLE;
        r_gnt   <= '0;
        r_led   <= 1'b0;
        r_ptr   <= w_next_ptr;
      end else if (w_tc) begin
        case (r_state)
          S_ON: begin
            r_state <= S_OFF;
            r_led   <= 1'b0;
          end
          S_OFF: begin
            if (r_rem > CNT_W'(1)) begin
              r_rem   <= r_rem - 1'b1;
              r_state <= S_ON;
              r_led   <= 1'b1;
            end else begin
              r_state <= S_GAP;
              r_gap   <= '0;
            end
          end
          default: begin
            if (r_gap == GAP_LAST) begin
              r_state <= S_IDLE;
              r_done  <= r_gnt;
              r_gnt   <= '0;
              r_ptr   <= w_next_ptr;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = !w_idle;
  assign led  = r_led;

endmodule
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_blink_sequencer
// Purpose  : Self-checking bench for blink_sequencer with HALF_PERIOD=4,
//            GAP_HALVES=2, NREQ=4, CNT_W=4. Per-cycle expectations for a
//            granted code come from a small timing model of the pulse train.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blink_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] blink_cnt;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        led;

  int checks = 0;
  int errors = 0;

  blink_sequencer #(
    .NREQ        (4),
    .HALF_PERIOD (4),
    .GAP_HALVES  (2),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .blink_cnt (blink_cnt),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    int         cnt;
    logic [3:0] exp_gnt;
    int         exp_done_t;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {gnt, done, busy, led} at cycle t after a grant (t=1 is the first granted
  // cycle). Pulse k is high for t in [8k+1, 8k+4]; completion at t=dt.
  function automatic logic [9:0] exp_vec(input logic [3:0] g, input int cnt,
                                         input int t, input int dt);
    logic [3:0] eg;
    logic [3:0] ed;
    logic       eb;
    logic       el;
    eg = (t < dt) ? g : 4'b0000;
    ed = (t == dt) ? g : 4'b0000;
    eb = (t < dt);
    el = (t <= 8 * cnt) && (((t - 1) % 8) < 4);
    return {eg, ed, eb, el};
  endfunction

  function automatic logic [9:0] outs();
    return {gnt, done, busy, led};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int vi);
    int field;
    field = 0;
    for (int b = 0; b < 4; b++) if (vecs[vi].req[b]) field = b;
    req       = vecs[vi].req;
    blink_cnt = '0;
    blink_cnt[field*4 +: 4] = 4'(vecs[vi].cnt);
    for (int t = 1; t <= vecs[vi].exp_done_t; t++) begin
      @(negedge clk);
      chk($sformatf("vec%0d t%0d", vi, t), 32'(outs()),
          32'(exp_vec(vecs[vi].exp_gnt, vecs[vi].cnt, t, vecs[vi].exp_done_t)));
      if (t == 2) blink_cnt = '1;   // late count change must be ignored
      if (t == vecs[vi].exp_done_t) req = 4'b0000;
    end
    @(negedge clk);
    chk($sformatf("vec%0d idle", vi), 32'(outs()), 32'd0);
    blink_cnt = '0;
  endtask

  initial begin
    vecs[0] = '{req: 4'b0010, cnt: 3,  exp_gnt: 4'b0010, exp_done_t: 33};
    vecs[1] = '{req: 4'b0100, cnt: 0,  exp_gnt: 4'b0100, exp_done_t: 9};
    vecs[2] = '{req: 4'b0001, cnt: 1,  exp_gnt: 4'b0001, exp_done_t: 17};
    vecs[3] = '{req: 4'b1000, cnt: 2,  exp_gnt: 4'b1000, exp_done_t: 25};
    vecs[4] = '{req: 4'b0010, cnt: 15, exp_gnt: 4'b0010, exp_done_t: 129};

    rst_n     = 1'b0;
    req       = '0;
    blink_cnt = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'(outs()), 32'd0);
    rst_n = 1'b1;

`ifdef BLINK_HEARTBEAT_EN
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      chk($sformatf("heartbeat n%0d", n), 32'(led), 32'((n / 8) % 2));
    end
`else
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      chk($sformatf("idle dark n%0d", n), 32'(outs()), 32'd0);
    end
`endif

    // Single-requester codes, including zero and maximum pulse counts.
    for (int vi = 0; vi < 5; vi++) run_vec(vi);

    // All four requesting with count 1: grants rotate 0,1,2,3,0.
    do_reset();
    req       = 4'b1111;
    blink_cnt = 16'h1111;
    for (int t = 1; t <= 85; t++) begin
      @(negedge clk);
      chk($sformatf("rr t%0d", t), 32'(outs()),
          32'(exp_vec(4'b0001 << (((t - 1) / 17) % 4), 1, ((t - 1) % 17) + 1, 17)));
      if (t == 85) req = 4'b0000;
    end
    @(negedge clk);
    chk("rr idle", 32'(outs()), 32'd0);

    // Abort: requester 0 drops during its second half-period.
    do_reset();
    req       = 4'b0001;
    blink_cnt = 16'h0002;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      chk($sformatf("abort t%0d", t), 32'(outs()), 32'(exp_vec(4'b0001, 2, t, 25)));
    end
    req = 4'b0000;
    @(negedge clk);
    chk("abort released", 32'(outs()), 32'd0);
    @(negedge clk);
    chk("abort no done", 32'(outs()), 32'd0);
    req = 4'b0011;
    @(negedge clk);
    chk("abort ptr moved", 32'(gnt), 32'h2);
    req = 4'b0000;
    @(negedge clk);
    chk("abort 1 released", 32'(outs()), 32'd0);

    // Pointer now 2; reset mid-ON must restart arbitration from requester 0.
    req       = 4'b0111;
    blink_cnt = 16'h0111;
    @(negedge clk);
    chk("pre-reset grant", 32'(gnt), 32'h4);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-on reset", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset grant", 32'(outs()), 32'(exp_vec(4'b0001, 1, 1, 17)));
    req = 4'b0000;
    @(negedge clk);
    chk("final idle", 32'(outs()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
- Shared-LED controller. Up to NREQ requesters each ask to show a blink code: N pulses, then a gap.
- Round-robin arbiter grants the single LED to one requester at a time.
- An FSM plus a half-period prescaler sequences the pulses.
- Sits between status/diagnostic sources and the board LED pin; replaces direct free-running LED toggling.

Parameters:
- NREQ, 4, number of requesters (2..8)
- HALF_PERIOD, 50000000, clk cycles per LED ON or OFF phase (>=2)
- GAP_HALVES, 2, length of the post-code gap in half-periods (>=1)
- CNT_W, 4, width of each requester's pulse-count field

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous reset, active-low
- req  in  NREQ  level request per requester; held high until done
- blink_cnt  in  NREQ*CNT_W  pulse count per requester; field i = bits [i*CNT_W +: CNT_W]
- gnt  out  NREQ  one-hot grant; all-zero when idle
- done  out  NREQ  one-cycle pulse on completion of requester i's code
- busy  out  1  high while state != IDLE
- led  out  1  registered LED drive

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, gnt=0, done=0, busy=0, led=0, prescaler=0, rr pointer=0 (requester 0 has highest priority first).
- States: IDLE, ON, OFF, GAP.
- IDLE: if any req bit is high at posedge T, pick the first set bit searching from ptr upward with wrap. At T+1:
  - gnt=onehot(i), busy=1, state=ON, led=1.
  - remaining = blink_cnt field i, sampled at T.
  - prescaler cleared.
  - If the sampled count is 0: state=GAP and led=0 instead.
- Prescaler: counts 0..HALF_PERIOD-1 in any non-IDLE state. Terminal count (tc) is HALF_PERIOD-1. Each ON/OFF phase is exactly HALF_PERIOD cycles.
- ON at tc -> OFF, led=0.
- OFF at tc:
  - remaining>1: remaining-1, -> ON, led=1.
  - Otherwise -> GAP.
- GAP: lasts GAP_HALVES*HALF_PERIOD cycles. A phase counter tracks the half-periods.
- GAP at final tc -> IDLE next cycle. That cycle: done[i]=1, gnt=0, busy=0, ptr=i+1 mod NREQ.
- Earliest new grant is the cycle after done.
- Abort: req[i] deasserted while granted -> next cycle IDLE, led=0, gnt=0, no done, ptr=i+1.
- Changes to blink_cnt after grant are ignored.
- Requests arriving during a sequence wait; no queueing beyond the req level.
- Simultaneous requests: exactly one grant; round-robin guarantees each waiting requester is served within NREQ sequences.
- remaining is CNT_W bits; max code = 2^CNT_W-1 pulses. No wrap.
- Reset mid-sequence: immediate return to reset values at that posedge; no done.

Optional Feature:
- Macro: BLINK_HEARTBEAT_EN.
- Defined: in IDLE the prescaler free-runs and led toggles every 2*HALF_PERIOD cycles (idle heartbeat). On grant, led is forced per the ON rule and the prescaler is cleared. The heartbeat phase restarts at 0 (led=0) on return to IDLE.
- Undefined: led held 0 and prescaler held 0 in IDLE.

Decomposition:
- Package blink_seq_pkg:
  - state enum typedef (IDLE/ON/OFF/GAP)
  - prescaler width constant $clog2(HALF_PERIOD)
  - gap-counter width constant
- Sub-module blink_prescaler:
  - Ports: clk, rst_n, clr, en, tc.
  - Parameterised by HALF_PERIOD.
  - Instantiated once.
- Arbiter pick logic is a package function (rr_pick).

Test Plan (HALF_PERIOD=4, GAP_HALVES=2, NREQ=4):
- req[1]=1 and cnt1=3 at T:
  - gnt=0010 at T+1.
  - led high T+1..4, T+9..12, T+17..20; low otherwise.
  - GAP T+25..32.
  - done[1] pulse at T+33, gnt=0 at T+33.
- req=1111, all cnt=1, held:
  - grants follow order 0,1,2,3,0.
  - each sequence = 16 cycles plus 1 IDLE cycle.
  - exactly one done per grant.
- cnt2=0, req[2]=1:
  - led stays 0.
  - GAP 8 cycles.
  - done[2] at T+9.
- req[0] dropped at T+6 during cnt0=2:
  - T+7: state IDLE, led=0, gnt=0.
  - no done pulse.
  - the next request on 0 and 1 goes to 1.
- rst_n low for 1 cycle mid-ON: all outputs are 0 the next cycle; with req held, re-grant starts from requester 0.
- With BLINK_HEARTBEAT_EN and no req: led toggles every 8 cycles. After done, the first toggle comes 8 cycles later.
